// File: rtl/game_sequencer_if.sv
// Handshake-free bundle between the maze sequencer and its environment (buttons, map ROM, display).
// master = sequencer side, slave = environment side.
interface game_sequencer_if #(
    parameter int MAP_W = 30
);
    logic [3:0]       SCENs;
    logic [4:0]       rom_addr;
    logic [MAP_W-1:0] rom_data;
    logic [2:0]       game_state;
    logic [1:0]       difficulty;
    logic             show_map;
    logic [7:0]       player_x_pos;
    logic [7:0]       player_y_pos;
    logic             lost;
    logic             won;

    modport master (
        input  SCENs, rom_data,
        output rom_addr, game_state, difficulty, show_map,
               player_x_pos, player_y_pos, lost, won
    );

    modport slave (
        output SCENs, rom_data,
        input  rom_addr, game_state, difficulty, show_map,
               player_x_pos, player_y_pos, lost, won
    );
endinterface

// File: rtl/game_sequencer.sv
// Maze game sequencer: difficulty menu, timed map reveal, ROM-checked moves, win/lose handling.
// Move-to-commit takes a 2-cycle CHECK; button pulses outside MENU/PLAY/LOST/WON are dropped.
module game_sequencer #(
    parameter int MAP_W     = 30,
    parameter int MAP_H     = 21,
    parameter int START_X   = 0,
    parameter int START_Y   = 20,
    parameter int GOAL_X    = 29,
    parameter int GOAL_Y    = 0,
    parameter int SHOW_UNIT = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    game_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        MENU  = 3'd0,
        SHOW  = 3'd1,
        PLAY  = 3'd2,
        CHECK = 3'd3,
        LOST  = 3'd4,
        WON   = 3'd5
    } state_t;

    localparam int          XW      = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam logic [8:0]  W9      = 9'(MAP_W);
    localparam logic [8:0]  H9      = 9'(MAP_H);
    localparam logic [7:0]  SX8     = 8'(START_X);
    localparam logic [7:0]  SY8     = 8'(START_Y);
    localparam logic [4:0]  SY5     = 5'(START_Y);
    localparam logic [7:0]  GX8     = 8'(GOAL_X);
    localparam logic [7:0]  GY8     = 8'(GOAL_Y);
    localparam logic [31:0] LOAD_E  = 32'(4 * SHOW_UNIT);
    localparam logic [31:0] LOAD_M  = 32'(2 * SHOW_UNIT);
    localparam logic [31:0] LOAD_H  = 32'(SHOW_UNIT);

    state_t      state_q;
    logic [1:0]  diff_q;
    logic [7:0]  px_q, py_q;
    logic [7:0]  cx_q, cy_q;
    logic [31:0] timer_q;
    logic        chk_q;
    logic [4:0]  addr_q;
    logic        show_q, lost_q, won_q;

    logic [8:0]  cand_x_d, cand_y_d;
    logic        move_vld, in_range;
    logic [31:0] load_val;

    // Lowest-indexed button wins; 9-bit math turns an underflow into an out-of-range value.
    always_comb begin
        cand_x_d = {1'b0, px_q};
        cand_y_d = {1'b0, py_q};
        move_vld = 1'b0;
        if (bus.SCENs[0]) begin
            cand_y_d = {1'b0, py_q} - 9'd1;
            move_vld = 1'b1;
        end else if (bus.SCENs[1]) begin
            cand_y_d = {1'b0, py_q} + 9'd1;
            move_vld = 1'b1;
        end else if (bus.SCENs[2]) begin
            cand_x_d = {1'b0, px_q} - 9'd1;
            move_vld = 1'b1;
        end else if (bus.SCENs[3]) begin
            cand_x_d = {1'b0, px_q} + 9'd1;
            move_vld = 1'b1;
        end
        in_range = move_vld && (cand_x_d < W9) && (cand_y_d < H9);
    end

    always_comb begin
        load_val = LOAD_E;
        case (diff_q)
            2'd1:    load_val = LOAD_M;
            2'd2:    load_val = LOAD_H;
            default: load_val = LOAD_E;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MENU;
            diff_q  <= 2'd0;
            px_q    <= SX8;
            py_q    <= SY8;
            cx_q    <= SX8;
            cy_q    <= SY8;
            timer_q <= 32'd0;
            chk_q   <= 1'b0;
            addr_q  <= SY5;
            show_q  <= 1'b0;
            lost_q  <= 1'b0;
            won_q   <= 1'b0;
        end else begin
            case (state_q)
                MENU: begin
                    if (bus.SCENs[0]) begin
                        timer_q <= load_val;
                        state_q <= SHOW;
                        show_q  <= 1'b1;
                    end else if (bus.SCENs[1]) begin
                        diff_q <= diff_q;
                    end else if (bus.SCENs[2]) begin
                        diff_q <= (diff_q == 2'd0) ? 2'd2 : diff_q - 2'd1;
                    end else if (bus.SCENs[3]) begin
                        diff_q <= (diff_q >= 2'd2) ? 2'd0 : diff_q + 2'd1;
                    end
                end
                SHOW: begin
                    // Leaving when the count is about to hit zero gives exactly load_val SHOW cycles.
                    if (timer_q <= 32'd1) begin
                        timer_q <= 32'd0;
                        state_q <= PLAY;
                        show_q  <= 1'b0;
                    end else begin
                        timer_q <= timer_q - 32'd1;
                    end
                end
                PLAY: begin
                    if (in_range) begin
                        cx_q    <= cand_x_d[7:0];
                        cy_q    <= cand_y_d[7:0];
                        addr_q  <= cand_y_d[4:0];
                        chk_q   <= 1'b0;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (!chk_q) begin
                        chk_q <= 1'b1;
                    end else if (bus.rom_data[cx_q[XW-1:0]]) begin
                        state_q <= LOST;
                        lost_q  <= 1'b1;
                        addr_q  <= py_q[4:0];
                    end else begin
                        px_q <= cx_q;
                        py_q <= cy_q;
                        if (cx_q == GX8 && cy_q == GY8) begin
                            state_q <= WON;
                            won_q   <= 1'b1;
                        end else begin
                            state_q <= PLAY;
                        end
                    end
                end
                LOST, WON: begin
                    if (|bus.SCENs) begin
                        state_q <= MENU;
                        lost_q  <= 1'b0;
                        won_q   <= 1'b0;
                        px_q    <= SX8;
                        py_q    <= SY8;
                        addr_q  <= SY5;
                    end
                end
                default: state_q <= MENU;
            endcase
        end
    end

    assign bus.rom_addr     = addr_q;
    assign bus.game_state   = state_q;
    assign bus.difficulty   = diff_q;
    assign bus.show_map     = show_q;
    assign bus.player_x_pos = px_q;
    assign bus.player_y_pos = py_q;
    assign bus.lost         = lost_q;
    assign bus.won          = won_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed scenarios plus randomized games checked against a grid-level model.
module tb_game_sequencer;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [29:0] rom [21];
    int m_x, m_y, m_diff;

    game_sequencer_if #(.MAP_W(30)) bus ();

    game_sequencer #(.SHOW_UNIT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Registered map ROM: data reflects the address seen at the previous edge.
    always @(posedge clk) bus.rom_data <= (bus.rom_addr < 5'd21) ? rom[bus.rom_addr] : 30'd0;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic press(input logic [3:0] b);
        @(posedge clk); #1 bus.SCENs = b;
        @(posedge clk); #1 bus.SCENs = 4'b0;
    endtask

    task automatic clear_rom();
        for (int r = 0; r < 21; r++) rom[r] = 30'd0;
    endtask

    task automatic start_game(input int want);
        int n;
        for (int i = 0; i < 3 && m_diff != want; i++) begin
            press(4'b1000);
            m_diff = (m_diff + 1) % 3;
        end
        press(4'b0001);
        n = 0;
        while (bus.game_state !== 3'd2 && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL start_game_timeout state=%0d expected 2", bus.game_state);
        end
        m_x = 0; m_y = 20;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #23;
        checks++;
        if (bus.game_state !== 3'd0 || bus.difficulty !== 2'd0 || bus.player_x_pos !== 8'd0 ||
            bus.player_y_pos !== 8'd20 || bus.rom_addr !== 5'd20 || bus.show_map !== 1'b0 ||
            bus.lost !== 1'b0 || bus.won !== 1'b0) begin
            errors++;
            $display("FAIL reset_state st=%0d diff=%0d x=%0d y=%0d addr=%0d show=%b lost=%b won=%b expected 0 0 0 20 20 0 0 0",
                     bus.game_state, bus.difficulty, bus.player_x_pos, bus.player_y_pos,
                     bus.rom_addr, bus.show_map, bus.lost, bus.won);
        end
        @(negedge clk) reset = 1'b1;
        m_diff = 0;
    endtask

    task automatic test_difficulty();
        press(4'b0100);
        m_diff = (m_diff + 2) % 3;
        checks++;
        if (bus.difficulty !== 2'(m_diff)) begin
            errors++;
            $display("FAIL diff_wrap_down got %0d expected %0d", bus.difficulty, m_diff);
        end
        press(4'b1000);
        press(4'b1000);
        m_diff = (m_diff + 2) % 3;
        checks++;
        if (bus.difficulty !== 2'(m_diff)) begin
            errors++;
            $display("FAIL diff_wrap_up got %0d expected %0d", bus.difficulty, m_diff);
        end
        press(4'b0010);
        checks++;
        if (bus.difficulty !== 2'(m_diff) || bus.game_state !== 3'd0) begin
            errors++;
            $display("FAIL menu_down_ignored diff=%0d st=%0d expected %0d 0", bus.difficulty, bus.game_state, m_diff);
        end
    endtask

    task automatic test_show();
        int n, exp_n;
        exp_n = 10 * (4 >> m_diff);
        press(4'b0001);
        n = 0;
        while (bus.show_map === 1'b1 && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (n != exp_n || bus.game_state !== 3'd2) begin
            errors++;
            $display("FAIL show_timing cycles=%0d st=%0d expected %0d 2", n, bus.game_state, exp_n);
        end
        m_x = 0; m_y = 20;
    endtask

    task automatic test_legal_move();
        rom[19] = 30'd0;
        press(4'b0001);
        checks++;
        if (bus.game_state !== 3'd3 || bus.rom_addr !== 5'd19) begin
            errors++;
            $display("FAIL move_enter_check st=%0d addr=%0d expected 3 19", bus.game_state, bus.rom_addr);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.game_state !== 3'd3 || bus.player_y_pos !== 8'd20) begin
            errors++;
            $display("FAIL move_mid_check st=%0d y=%0d expected 3 20", bus.game_state, bus.player_y_pos);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.player_x_pos !== 8'd0 || bus.player_y_pos !== 8'd19 || bus.game_state !== 3'd2 ||
            bus.rom_addr !== 5'd19) begin
            errors++;
            $display("FAIL move_commit x=%0d y=%0d st=%0d addr=%0d expected 0 19 2 19",
                     bus.player_x_pos, bus.player_y_pos, bus.game_state, bus.rom_addr);
        end
        m_y = 19;
    endtask

    task automatic test_boundary();
        press(4'b0100);
        checks++;
        if (bus.game_state !== 3'd2 || bus.rom_addr !== 5'd19) begin
            errors++;
            $display("FAIL boundary_no_read st=%0d addr=%0d expected 2 19", bus.game_state, bus.rom_addr);
        end
        repeat (2) @(posedge clk); #1;
        checks++;
        if (bus.game_state !== 3'd2 || bus.player_x_pos !== 8'd0 || bus.player_y_pos !== 8'd19) begin
            errors++;
            $display("FAIL boundary_hold st=%0d x=%0d y=%0d expected 2 0 19",
                     bus.game_state, bus.player_x_pos, bus.player_y_pos);
        end
        press(4'b1010);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (bus.game_state !== 3'd2 || bus.player_x_pos !== 8'd0 || bus.player_y_pos !== 8'd20) begin
            errors++;
            $display("FAIL priority_down st=%0d x=%0d y=%0d expected 2 0 20",
                     bus.game_state, bus.player_x_pos, bus.player_y_pos);
        end
        m_y = 20;
    endtask

    task automatic test_wall();
        rom[19] = 30'd1;
        press(4'b0001);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (bus.lost !== 1'b1 || bus.won !== 1'b0 || bus.game_state !== 3'd4 ||
            bus.player_x_pos !== 8'd0 || bus.player_y_pos !== 8'd20) begin
            errors++;
            $display("FAIL wall_hit lost=%b won=%b st=%0d x=%0d y=%0d expected 1 0 4 0 20",
                     bus.lost, bus.won, bus.game_state, bus.player_x_pos, bus.player_y_pos);
        end
        press(4'b0010);
        checks++;
        if (bus.game_state !== 3'd0 || bus.lost !== 1'b0 || bus.player_x_pos !== 8'd0 ||
            bus.player_y_pos !== 8'd20 || bus.difficulty !== 2'(m_diff) || bus.rom_addr !== 5'd20) begin
            errors++;
            $display("FAIL lost_to_menu st=%0d lost=%b x=%0d y=%0d diff=%0d addr=%0d expected 0 0 0 20 %0d 20",
                     bus.game_state, bus.lost, bus.player_x_pos, bus.player_y_pos, bus.difficulty,
                     bus.rom_addr, m_diff);
        end
        rom[19] = 30'd0;
    endtask

    task automatic test_goal();
        clear_rom();
        start_game(2);
        for (int i = 0; i < 29; i++) begin
            press(4'b1000);
            repeat (2) @(posedge clk); #1;
        end
        for (int i = 0; i < 19; i++) begin
            press(4'b0001);
            repeat (2) @(posedge clk); #1;
        end
        checks++;
        if (bus.player_x_pos !== 8'd29 || bus.player_y_pos !== 8'd1 || bus.game_state !== 3'd2 || bus.won !== 1'b0) begin
            errors++;
            $display("FAIL goal_approach x=%0d y=%0d st=%0d won=%b expected 29 1 2 0",
                     bus.player_x_pos, bus.player_y_pos, bus.game_state, bus.won);
        end
        press(4'b0001);
        repeat (2) @(posedge clk); #1;
        checks++;
        if (bus.won !== 1'b1 || bus.lost !== 1'b0 || bus.game_state !== 3'd5 ||
            bus.player_x_pos !== 8'd29 || bus.player_y_pos !== 8'd0) begin
            errors++;
            $display("FAIL goal_won won=%b lost=%b st=%0d x=%0d y=%0d expected 1 0 5 29 0",
                     bus.won, bus.lost, bus.game_state, bus.player_x_pos, bus.player_y_pos);
        end
        press(4'b1000);
        checks++;
        if (bus.game_state !== 3'd0 || bus.won !== 1'b0 || bus.player_x_pos !== 8'd0 || bus.player_y_pos !== 8'd20) begin
            errors++;
            $display("FAIL won_to_menu st=%0d won=%b x=%0d y=%0d expected 0 0 0 20",
                     bus.game_state, bus.won, bus.player_x_pos, bus.player_y_pos);
        end
    endtask

    task automatic test_reset_abort();
        press(4'b0001);
        repeat (3) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (bus.game_state !== 3'd0 || bus.show_map !== 1'b0 || bus.difficulty !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_show st=%0d show=%b diff=%0d expected 0 0 0",
                     bus.game_state, bus.show_map, bus.difficulty);
        end
        @(negedge clk) reset = 1'b1;
        m_diff = 0;
        repeat (60) @(posedge clk); #1;
        checks++;
        if (bus.game_state !== 3'd0 || bus.show_map !== 1'b0) begin
            errors++;
            $display("FAIL reset_show_stays_menu st=%0d show=%b expected 0 0", bus.game_state, bus.show_map);
        end
        clear_rom();
        start_game(2);
        press(4'b0001);
        #3 reset = 1'b0;
        #1;
        checks++;
        if (bus.game_state !== 3'd0 || bus.player_x_pos !== 8'd0 || bus.player_y_pos !== 8'd20 ||
            bus.rom_addr !== 5'd20 || bus.lost !== 1'b0 || bus.won !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_check st=%0d x=%0d y=%0d addr=%0d expected 0 0 20 20",
                     bus.game_state, bus.player_x_pos, bus.player_y_pos, bus.rom_addr);
        end
        @(negedge clk) reset = 1'b1;
        m_diff = 0;
        @(posedge clk); #1;
        checks++;
        if (bus.game_state !== 3'd0 || bus.player_y_pos !== 8'd20) begin
            errors++;
            $display("FAIL reset_release_menu st=%0d y=%0d expected 0 20", bus.game_state, bus.player_y_pos);
        end
    endtask

    task automatic test_random();
        logic [3:0] b;
        int bi, nx, ny, exp_st;
        bit inr;
        for (int g = 0; g < 6; g++) begin
            for (int r = 0; r < 21; r++) rom[r] = 30'($urandom & $urandom & $urandom);
            rom[20][0] = 1'b0;
            start_game(int'($urandom_range(0, 2)));
            checks++;
            if (bus.difficulty !== 2'(m_diff)) begin
                errors++;
                $display("FAIL rand_difficulty got %0d expected %0d", bus.difficulty, m_diff);
            end
            exp_st = 2;
            for (int mv = 0; mv < 60 && exp_st == 2; mv++) begin
                b = 4'($urandom_range(1, 15));
                bi = 0;
                while (!b[bi]) bi++;
                nx = m_x; ny = m_y;
                case (bi)
                    0: ny = ny - 1;
                    1: ny = ny + 1;
                    2: nx = nx - 1;
                    default: nx = nx + 1;
                endcase
                inr = (nx >= 0 && nx < 30 && ny >= 0 && ny < 21);
                if (!inr) exp_st = 2;
                else if (rom[ny][nx]) exp_st = 4;
                else begin
                    m_x = nx; m_y = ny;
                    exp_st = (nx == 29 && ny == 0) ? 5 : 2;
                end
                press(b);
                if (inr && $urandom_range(0, 1) == 1) begin
                    bus.SCENs = 4'($urandom_range(1, 15));
                    @(posedge clk); #1 bus.SCENs = 4'b0;
                    @(posedge clk); #1;
                end else begin
                    repeat (2) @(posedge clk); #1;
                end
                checks++;
                if (bus.game_state !== 3'(exp_st) || bus.player_x_pos !== 8'(m_x) || bus.player_y_pos !== 8'(m_y) ||
                    bus.rom_addr !== 5'(m_y) || bus.lost !== (exp_st == 4) || bus.won !== (exp_st == 5)) begin
                    errors++;
                    $display("FAIL rand_move g=%0d btn=%b st=%0d x=%0d y=%0d addr=%0d lost=%b won=%b expected st=%0d x=%0d y=%0d",
                             g, b, bus.game_state, bus.player_x_pos, bus.player_y_pos, bus.rom_addr,
                             bus.lost, bus.won, exp_st, m_x, m_y);
                end
            end
            if (exp_st != 2) begin
                press(4'($urandom_range(1, 15)));
                checks++;
                if (bus.game_state !== 3'd0 || bus.player_x_pos !== 8'd0 || bus.player_y_pos !== 8'd20 ||
                    bus.difficulty !== 2'(m_diff)) begin
                    errors++;
                    $display("FAIL rand_to_menu st=%0d x=%0d y=%0d diff=%0d expected 0 0 20 %0d",
                             bus.game_state, bus.player_x_pos, bus.player_y_pos, bus.difficulty, m_diff);
                end
            end else begin
                @(negedge clk) reset = 1'b0;
                @(negedge clk) reset = 1'b1;
                m_diff = 0;
                #1;
            end
        end
    endtask

    initial begin
        bus.SCENs = 4'b0;
        reset = 1'b1;
        clear_rom();
        m_diff = 0; m_x = 0; m_y = 20;
        test_reset();
        test_difficulty();
        test_show();
        test_legal_move();
        test_boundary();
        test_wall();
        test_goal();
        test_reset_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameters SHALL be: MAP_W, default 30, map columns; MAP_H, default 21, map rows; START_X, default 0, player start column; START_Y, default 20, player start row; GOAL_X, default 29, goal column; GOAL_Y, default 0, goal row; SHOW_UNIT, default 25000000, base show-map time in clk cycles.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 SCENs  input  4  single-cycle debounced button pulses: [0] up/select, [1] down, [2] left, [3] right.
REQ-005 rom_addr  output  5  map ROM row address (registered).
REQ-006 rom_data  input  30  map ROM row data, valid exactly 1 clk after rom_addr changes; bit n=1 means wall at column n.
REQ-007 game_state  output  3  0=MENU, 1=SHOW, 2=PLAY, 3=CHECK, 4=LOST, 5=WON.
REQ-008 difficulty  output  2  0=easy, 1=medium, 2=hard.
REQ-009 show_map  output  1  high only in SHOW.
REQ-010 player_x_pos / player_y_pos  output  8 each  committed player column/row.
REQ-011 lost / won  output  1 each  high only in LOST / WON respectively.

Function
REQ-012 All outputs SHALL be registered; no output SHALL depend combinationally on SCENs or rom_data.
REQ-013 When several SCENs bits are set in one cycle, only the lowest-indexed bit SHALL be acted on.
REQ-014 MENU: SCENs[2] decrements difficulty (0 wraps to 2); SCENs[3] increments it (2 wraps to 0); SCENs[0] loads the show timer and enters SHOW; SCENs[1] is ignored.
REQ-015 Show timer load values SHALL be 4*SHOW_UNIT (easy), 2*SHOW_UNIT (medium), 1*SHOW_UNIT (hard), held in a 32-bit down-counter.
REQ-016 SHOW: the counter decrements every cycle, buttons are ignored, and the block enters PLAY on the cycle the counter reaches 0; SHOW SHALL last exactly the loaded count in cycles.
REQ-017 PLAY: a move pulse SHALL form a candidate position: up y-1, down y+1, left x-1, right x+1.
REQ-018 A candidate outside 0..MAP_W-1 or 0..MAP_H-1 SHALL be discarded, with no ROM read and the state remaining PLAY.
REQ-019 For an in-range candidate, the block SHALL drive rom_addr with the candidate row on the next edge and enter CHECK.
REQ-020 CHECK SHALL last exactly 2 cycles: one for the ROM address, one to sample rom_data. SCENs pulses arriving during CHECK SHALL be dropped.
REQ-021 End of CHECK:
- rom_data[cand_x]=1: enter LOST; player position not updated.
- Otherwise: commit the candidate to player_x_pos/player_y_pos; enter WON if the candidate equals (GOAL_X, GOAL_Y), else return to PLAY.
REQ-022 Move-to-commit latency SHALL be 3 cycles from the SCENs pulse edge to the updated player_*_pos.
REQ-023 LOST/WON: any SCENs pulse SHALL return to MENU, restore the player to (START_X, START_Y), and keep the current difficulty.
REQ-024 In every state other than CHECK, rom_addr SHALL hold player_y_pos.

Reset
REQ-025 While reset is low, regardless of clk, the block SHALL hold:
- game_state=MENU, difficulty=0
- player_x_pos=START_X, player_y_pos=START_Y
- rom_addr=START_Y
- show_map=0, lost=0, won=0
- show counter=0
REQ-026 Reset asserted mid-SHOW or mid-CHECK SHALL abort the operation immediately with no position commit; the first edge after reset release SHALL see MENU.

Verification
REQ-027 Difficulty wrap: in MENU, pulse SCENs[2] once -> difficulty=2; then pulse SCENs[3] twice -> difficulty=1.
REQ-028 Show timing: SHOW_UNIT=10, difficulty=1, pulse SCENs[0] -> show_map high for exactly 20 cycles, then game_state=2.
REQ-029 Legal move: player at (0,20), rom row 19 = 0, pulse SCENs[0] -> 3 cycles later player=(0,19), game_state=2.
REQ-030 Wall hit: rom row 19 bit 0 = 1, pulse SCENs[0] -> lost=1, game_state=4, player stays (0,20); then pulse SCENs[1] -> MENU, player=(0,20).
REQ-031 Boundary and priority:
- Player at x=0, pulse SCENs[2] -> no ROM read, stays PLAY.
- SCENs=4'b1010 -> treated as down only.
REQ-032 Goal and reset: step from (29,1) up into the open (29,0) -> won=1; reset pulsed low during a CHECK -> MENU, player=(0,20), no commit.
